seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 123 ++++++++++++
 tb/tb_seg_scan_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit seven-segment scanner that shows the register-file
// entries flagged by the queue's valid bits, with a blanking gap between digits.
module seg_scan_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] valid,
    input  logic [3:0] rd,
    output logic [2:0] ra,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    dreg_q;
    logic          vreg_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          tick;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] digit_sel(input logic [2:0] i);
        return ~(8'h01 << i);
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;
    end

    // Outputs are computed for the state being entered, so an/seg line up
    // with cnt: the digit lights on the cycle where cnt == BLANK_CYC+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            state_q <= ST_BLANK;
            dreg_q  <= 4'h0;
            vreg_q  <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (tick) begin
                state_q <= ST_BLANK;
                an_q    <= 8'hFF;
                seg_q   <= 7'h7F;
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        an_q  <= 8'hFF;
                        seg_q <= 7'h7F;
                        if (cnt_q == BLANK_LAST) begin
                            state_q <= ST_LATCH;
                        end
                    end
                    ST_LATCH: begin
                        dreg_q  <= rd;
                        vreg_q  <= valid[idx_q];
                        state_q <= ST_SHOW;
                        an_q    <= valid[idx_q] ? digit_sel(idx_q) : 8'hFF;
                        seg_q   <= valid[idx_q] ? hex7(rd) : 7'h7F;
                    end
                    ST_SHOW: begin
                        // Only the latched copy is shown; live inputs are ignored.
                        an_q  <= vreg_q ? digit_sel(idx_q) : 8'hFF;
                        seg_q <= vreg_q ? hex7(dreg_q) : 7'h7F;
                    end
                    default: begin
                        state_q <= ST_BLANK;
                        an_q    <= 8'hFF;
                        seg_q   <= 7'h7F;
                    end
                endcase
            end
        end
    end

    assign ra  = idx_q;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=8, BLANK_CYC=2: table of
// whole-scan vectors plus hand sequences for mid-slot change and async reset.
module tb_seg_scan_display;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk;
    logic       rst;
    logic [7:0] valid;
    logic [3:0] rd;
    logic [2:0] ra;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [31:0] rd_word;

    int checks;
    int errors;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [7:0]  valid;
        logic [31:0] rd_word;
        logic [7:0]  exp_lit;
    } scan_vec_t;

    scan_vec_t vecs [5];

    seg_scan_display #(
        .SCAN_DIV (SD),
        .BLANK_CYC(BC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .valid(valid),
        .rd   (rd),
        .ra   (ra),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    // Register file model: combinational read of the addressed nibble.
    always_comb rd = rd_word[{ra, 2'b00} +: 4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] ea,
                         input logic [6:0] es, input logic [2:0] er);
        checks++;
        if (an !== ea || seg !== es || ra !== er || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%b ra=%0d dp=%b, required an=%h seg=%b ra=%0d dp=1",
                     name, an, seg, ra, dp, ea, es, er);
        end
    endtask

    // Expected outputs at cycle c (0..63) of a scan that started at cnt=0, digit 0.
    function automatic void model(input int c, input logic [7:0] lit, input logic [31:0] w,
                                  output logic [7:0] ea, output logic [6:0] es,
                                  output logic [2:0] er);
        int slot;
        int cpos;
        slot = c / SD;
        cpos = c % SD;
        er   = 3'(slot);
        if (cpos <= BC || !lit[slot]) begin
            ea = 8'hFF;
            es = 7'h7F;
        end else begin
            ea = ~(8'h01 << slot);
            es = SEG_REF[w[slot*4 +: 4]];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the negedge of cnt=0 of digit 0; leaves at the same point one scan later.
    task automatic run_scan(input string tag, input logic [7:0] v, input logic [31:0] w,
                            input logic [7:0] lit);
        logic [7:0] ea;
        logic [6:0] es;
        logic [2:0] er;
        int e0;
        e0 = errors;
        valid   = v;
        rd_word = w;
        for (int c = 0; c < 8 * SD; c++) begin
            model(c, lit, w, ea, es, er);
            check($sformatf("%s c%0d", tag, c), ea, es, er);
            step();
        end
        check($sformatf("%s wrap", tag), 8'hFF, 7'h7F, 3'd0);
        $display("scan %s valid=%h rd=%h errors_in_scan=%0d", tag, v, w, errors - e0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        valid   = 8'h00;
        rd_word = 32'h0;

        vecs[0] = '{valid: 8'h01, rd_word: 32'h0000_0005, exp_lit: 8'h01};
        vecs[1] = '{valid: 8'hFF, rd_word: 32'hFEDC_BA98, exp_lit: 8'hFF};
        vecs[2] = '{valid: 8'h00, rd_word: 32'h1234_5678, exp_lit: 8'h00};
        vecs[3] = '{valid: 8'hA5, rd_word: 32'h0123_4567, exp_lit: 8'hA5};
        vecs[4] = '{valid: 8'h5A, rd_word: 32'h7654_3210, exp_lit: 8'h5A};

        repeat (3) @(posedge clk);
        #2;
        valid   = 8'hFF;
        rd_word = 32'hFFFF_FFFF;
        check("reset_hold", 8'hFF, 7'h7F, 3'd0);
        valid   = vecs[0].valid;
        rd_word = vecs[0].rd_word;
        #1 rst = 1'b1;
        @(negedge clk);

        // First slot after release, written out by hand.
        for (int c = 0; c < 3; c++) begin
            check($sformatf("first_slot_blank c%0d", c), 8'hFF, 7'h7F, 3'd0);
            step();
        end
        for (int c = 3; c < 8; c++) begin
            check($sformatf("first_slot_lit c%0d", c), 8'hFE, 7'b0010010, 3'd0);
            step();
        end
        check("first_slot_next", 8'hFF, 7'h7F, 3'd1);
        repeat (7 * SD) step();

        for (int i = 0; i < 5; i++) begin
            run_scan($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rd_word, vecs[i].exp_lit);
        end

        // Valid/rd change in the middle of digit 0's SHOW must not reach the display.
        valid   = 8'h01;
        rd_word = 32'h0000_0003;
        for (int c = 0; c < 8 * SD; c++) begin
            if (c == 5) begin
                valid   = 8'h00;
                rd_word = 32'h0000_0009;
            end
            if (c >= 3 && c < 8)
                check($sformatf("midslot_hold c%0d", c), 8'hFE, SEG_REF[3], 3'd0);
            else
                check($sformatf("midslot_other c%0d", c), 8'hFF, 7'h7F, 3'(c / SD));
            step();
        end
        for (int c = 0; c < 8 * SD; c++) begin
            check($sformatf("midslot_dark c%0d", c), 8'hFF, 7'h7F, 3'(c / SD));
            step();
        end
        $display("scan midslot done errors=%0d", errors);

        for (int v = 0; v < 16; v++) begin
            run_scan($sformatf("dec%0d", v), 8'h01, {28'h0, 4'(v)}, 8'h01);
        end

        // Asynchronous reset during SHOW of digit 3.
        valid   = 8'hFF;
        rd_word = 32'hFEDC_BA98;
        repeat (3 * SD + 4) step();
        check("async_pre", 8'hF7, SEG_REF[4'hB], 3'd3);
        #1 rst = 1'b0;
        #1 check("async_immediate", 8'hFF, 7'h7F, 3'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("async_restart c0", 8'hFF, 7'h7F, 3'd0);
        step();
        check("async_restart c1", 8'hFF, 7'h7F, 3'd0);
        step();
        check("async_restart c2", 8'hFF, 7'h7F, 3'd0);
        step();
        check("async_restart c3", 8'hFE, SEG_REF[8], 3'd0);
        $display("async reset sequence done errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
